// File: rtl/dtw_ref_mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dtw_ref_mem_ctrl_pkg
// Shared definitions for the DTW reference memory controller: default
// parameter values and the controller FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package dtw_ref_mem_ctrl_pkg;

    localparam int DEF_WIDTH   = 16;  // reference sample width
    localparam int DEF_PTR_WID = 18;  // reference memory address width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_READ = 2'd2
    } state_t;

endpackage

// File: rtl/dtw_ref_rd_fifo.sv
// -----------------------------------------------------------------------------
// dtw_ref_rd_fifo
// Two-entry FIFO with valid/ready on both sides. Buffers memory read data so
// the read stream can stall without losing samples.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   s_data/s_valid/s_ready write side
//   m_data/m_valid/m_ready read side (m_data is the head entry, stable while
//                          m_valid=1 and m_ready=0)
// -----------------------------------------------------------------------------
module dtw_ref_rd_fifo #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [W-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready
);

    logic [W-1:0] entry [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    assign s_ready = (count != 2'd2);
    assign m_valid = (count != 2'd0);
    assign m_data  = entry[rd_ptr];
    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset too, so m_data reads 0 while in reset.
            for (int i = 0; i < 2; i++) entry[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                entry[wr_ptr] <= s_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/dtw_ref_mem_ctrl.sv
// -----------------------------------------------------------------------------
// dtw_ref_mem_ctrl
// Loads a reference sequence from a valid/ready stream into an external
// dual-port memory (port A write, port B read-only, 1-cycle read latency)
// and streams it back out on request with full throughput.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   load_start, rd_start, ref_len   operation requests; ref_len sampled on load
//   s_data/s_valid/s_ready          load stream
//   m_data/m_valid/m_ready/m_last   read stream
//   mem_wen_a/mem_addr_a/mem_din_a  memory write port
//   mem_addr_b/mem_dout_b           memory read port
//   busy, ref_loaded, loaded_len    status
//   done, err                       one-cycle completion / rejection pulses
// -----------------------------------------------------------------------------
module dtw_ref_mem_ctrl
    import dtw_ref_mem_ctrl_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int PTR_WID = DEF_PTR_WID
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_start,
    input  logic               rd_start,
    input  logic [PTR_WID:0]   ref_len,
    input  logic [WIDTH-1:0]   s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [WIDTH-1:0]   m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last,
    output logic               mem_wen_a,
    output logic [PTR_WID-1:0] mem_addr_a,
    output logic [WIDTH-1:0]   mem_din_a,
    output logic [PTR_WID-1:0] mem_addr_b,
    input  logic [WIDTH-1:0]   mem_dout_b,
    output logic               busy,
    output logic               ref_loaded,
    output logic [PTR_WID:0]   loaded_len,
    output logic               done,
    output logic               err
);

    localparam logic [PTR_WID:0] ONE     = {{PTR_WID{1'b0}}, 1'b1};
    localparam logic [PTR_WID:0] MAX_LEN = {1'b1, {PTR_WID{1'b0}}};

    state_t           state, state_nxt;
    // Counters are one bit wider than the address so a full-depth
    // reference (2^PTR_WID samples) still reaches its end count.
    logic [PTR_WID:0] wr_ptr;
    logic [PTR_WID:0] tgt_len;
    logic [PTR_WID:0] rd_addr;
    logic             rd_pend;    // port-B read issued last cycle
    logic             pend_last;  // that read was the final sample

    logic             len_ok, load_go, rd_go, start_bad;
    logic             beat, load_end, read_end, pop, issue;
    logic [1:0]       occ_hold;
    logic [2:0]       occ;

    logic             f_in_ready, f_out_valid;
    logic [WIDTH:0]   f_out_data;

    assign len_ok    = (ref_len != '0) && (ref_len <= MAX_LEN);
    // Load has priority; a simultaneous rd_start is simply dropped.
    assign load_go   = (state == ST_IDLE) && load_start && len_ok;
    assign rd_go     = (state == ST_IDLE) && !load_start && rd_start && ref_loaded;
    assign start_bad = (state == ST_IDLE) &&
                       ((load_start && !len_ok) || (!load_start && rd_start && !ref_loaded));

    assign beat      = (state == ST_LOAD) && s_valid;
    assign load_end  = beat && (wr_ptr == tgt_len - ONE);

    assign pop       = f_out_valid && m_ready;
    assign read_end  = pop && f_out_data[WIDTH];

    // Credit check: FIFO entries that survive this cycle plus the read in
    // flight must leave room for the read issued now. Counting the current
    // pop as freed space is what keeps the stream bubble-free at m_ready=1.
    assign occ_hold  = !f_in_ready ? 2'd2 : (f_out_valid ? 2'd1 : 2'd0);
    assign occ       = {1'b0, occ_hold} + {2'b0, rd_pend} - {2'b0, pop};
    assign issue     = (state == ST_READ) && (rd_addr != loaded_len) && (occ < 3'd2);

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        state_nxt  = state;
        busy       = (state != ST_IDLE);
        s_ready    = (state == ST_LOAD);
        mem_wen_a  = beat;
        mem_addr_a = wr_ptr[PTR_WID-1:0];
        mem_din_a  = beat ? s_data : '0;
        mem_addr_b = rd_addr[PTR_WID-1:0];
        unique case (state)
            ST_IDLE: begin
                if (load_go)    state_nxt = ST_LOAD;
                else if (rd_go) state_nxt = ST_READ;
            end
            ST_LOAD: if (load_end) state_nxt = ST_IDLE;
            ST_READ: if (read_end) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            tgt_len    <= '0;
            rd_addr    <= '0;
            rd_pend    <= 1'b0;
            pend_last  <= 1'b0;
            ref_loaded <= 1'b0;
            loaded_len <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples
            // pre-edge values regardless of statement order.
            state     <= state_nxt;
            done      <= load_end || read_end;
            err       <= start_bad;
            rd_pend   <= issue;
            pend_last <= issue && (rd_addr == loaded_len - ONE);

            if (load_go) begin
                wr_ptr     <= '0;
                tgt_len    <= ref_len;
                ref_loaded <= 1'b0;
            end else if (beat) begin
                wr_ptr <= wr_ptr + ONE;
            end

            if (load_end) begin
                ref_loaded <= 1'b1;
                loaded_len <= tgt_len;
            end

            if (rd_go)      rd_addr <= '0;
            else if (issue) rd_addr <= rd_addr + ONE;
        end
    end

    dtw_ref_rd_fifo #(.W(WIDTH + 1)) u_rd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_data  ({pend_last, mem_dout_b}),
        .s_valid (rd_pend),
        .s_ready (f_in_ready),
        .m_data  (f_out_data),
        .m_valid (f_out_valid),
        .m_ready (m_ready)
    );

    assign m_data  = f_out_data[WIDTH-1:0];
    assign m_valid = f_out_valid;
    assign m_last  = f_out_valid && f_out_data[WIDTH];

endmodule

// File: tb/tb_dtw_ref_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dtw_ref_mem_ctrl
// Self-checking bench for dtw_ref_mem_ctrl. A small array stands in for the
// external dual-port memory; the reference model is simply the queue of
// samples most recently loaded, which a read must replay in order.
// -----------------------------------------------------------------------------
module tb_dtw_ref_mem_ctrl;

    localparam int WIDTH   = 16;
    localparam int PTR_WID = 6;
    localparam int MAXL    = 1 << PTR_WID;

    logic               clk;
    logic               rst_n;
    logic               load_start, rd_start;
    logic [PTR_WID:0]   ref_len;
    logic [WIDTH-1:0]   s_data;
    logic               s_valid, s_ready;
    logic [WIDTH-1:0]   m_data;
    logic               m_valid, m_ready, m_last;
    logic               mem_wen_a;
    logic [PTR_WID-1:0] mem_addr_a, mem_addr_b;
    logic [WIDTH-1:0]   mem_din_a, mem_dout_b;
    logic               busy, ref_loaded, done, err;
    logic [PTR_WID:0]   loaded_len;

    int n_vec = 0;
    int n_err = 0;
    logic [WIDTH-1:0] model_q [$];

    dtw_ref_mem_ctrl #(.WIDTH(WIDTH), .PTR_WID(PTR_WID)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .rd_start   (rd_start),
        .ref_len    (ref_len),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .mem_wen_a  (mem_wen_a),
        .mem_addr_a (mem_addr_a),
        .mem_din_a  (mem_din_a),
        .mem_addr_b (mem_addr_b),
        .mem_dout_b (mem_dout_b),
        .busy       (busy),
        .ref_loaded (ref_loaded),
        .loaded_len (loaded_len),
        .done       (done),
        .err        (err)
    );

    // External memory: synchronous write on A, registered read on B.
    logic [WIDTH-1:0] mem_model [MAXL];
    always @(posedge clk) begin
        if (mem_wen_a) mem_model[mem_addr_a] <= mem_din_a;
        mem_dout_b <= mem_model[mem_addr_b];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   busy, 0);
        check({tag, "_loaded"}, ref_loaded, 0);
        check({tag, "_len"},    loaded_len, 0);
        check({tag, "_done"},   done, 0);
        check({tag, "_err"},    err, 0);
        check({tag, "_sready"}, s_ready, 0);
        check({tag, "_wen"},    mem_wen_a, 0);
        check({tag, "_addra"},  mem_addr_a, 0);
        check({tag, "_dina"},   mem_din_a, 0);
        check({tag, "_addrb"},  mem_addr_b, 0);
        check({tag, "_mvalid"}, m_valid, 0);
        check({tag, "_mdata"},  m_data, 0);
        check({tag, "_mlast"},  m_last, 0);
    endtask

    // A start that must be rejected: err for exactly one cycle, no state change.
    task automatic bad_start(input string tag, input bit ld, input bit rd, input int len);
        @(negedge clk);
        load_start = ld; rd_start = rd; ref_len = len[PTR_WID:0];
        @(negedge clk);
        load_start = 0; rd_start = 0;
        #1;
        check({tag, "_err"},  err, 1);
        check({tag, "_busy"}, busy, 0);
        @(negedge clk); #1;
        check({tag, "_err_clr"}, err, 0);
        check({tag, "_busy2"},   busy, 0);
    endtask

    // Load a reference; s_valid asserted with probability vprob percent.
    // Extra starts during the load must be ignored without err.
    task automatic load_ref(input logic [WIDTH-1:0] data [$], input bit with_rd, input int vprob);
        int len = data.size();
        int idx = 0;
        int cyc = 0;
        @(negedge clk);
        load_start = 1; rd_start = with_rd; ref_len = len[PTR_WID:0];
        @(negedge clk);
        load_start = 0; rd_start = 0;
        while (idx < len && cyc < 4000) begin
            s_valid    = ($urandom_range(99) < vprob);
            s_data     = s_valid ? data[idx] : WIDTH'($urandom);
            rd_start   = (cyc == 1);
            load_start = (cyc == 2);
            #1;
            check("ld_busy",   busy, 1);
            check("ld_sready", s_ready, 1);
            check("ld_err",    err, 0);
            check("ld_done",   done, 0);
            check("ld_mvalid", m_valid, 0);
            check("ld_wen",    mem_wen_a, s_valid);
            if (s_valid) begin
                check("ld_addr", mem_addr_a, idx);
                check("ld_data", mem_din_a, data[idx]);
                idx++;
            end
            cyc++;
            @(negedge clk);
        end
        s_valid = 0; rd_start = 0; load_start = 0;
        if (idx < len) check("ld_timeout", idx, len);
        #1;
        check("ld_end_done",   done, 1);
        check("ld_end_busy",   busy, 0);
        check("ld_end_loaded", ref_loaded, 1);
        check("ld_end_len",    loaded_len, len);
        check("ld_end_wen",    mem_wen_a, 0);
        model_q = data;
        @(negedge clk); #1;
        check("ld_done_clr", done, 0);
    endtask

    // Stream the stored reference. mode 0: m_ready=1, 1: pattern 1,0,0, 2: random.
    task automatic read_ref(input int mode);
        int len = model_q.size();
        int k = 0;
        int cyc = 1;
        bit prev_stall = 0;
        logic [WIDTH-1:0] prev_data = '0;
        logic prev_last = 0;
        @(negedge clk);
        rd_start = 1;
        @(negedge clk);
        rd_start = 0;
        while (k < len && cyc < 4000) begin
            case (mode)
                0:       m_ready = 1;
                1:       m_ready = (cyc % 3 == 0);
                default: m_ready = 1'($urandom_range(1));
            endcase
            #1;
            check("rd_busy", busy, 1);
            check("rd_done", done, 0);
            check("rd_sready", s_ready, 0);
            if (prev_stall) begin
                check("rd_hold_valid", m_valid, 1);
                check("rd_hold_data",  m_data, prev_data);
                check("rd_hold_last",  m_last, prev_last);
            end
            if (mode == 0) check("rd_mvalid_timing", m_valid, cyc >= 3);
            if (m_valid && m_ready) begin
                check("rd_data", m_data, model_q[k]);
                check("rd_last", m_last, k == len - 1);
                k++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            cyc++;
            @(negedge clk);
        end
        m_ready = 0;
        if (k < len) check("rd_timeout", k, len);
        #1;
        check("rd_end_done",   done, 1);
        check("rd_end_busy",   busy, 0);
        check("rd_end_mvalid", m_valid, 0);
        check("rd_end_loaded", ref_loaded, 1);
        @(negedge clk); #1;
        check("rd_done_clr", done, 0);
    endtask

    initial begin
        logic [WIDTH-1:0] q [$];
        int len;

        rst_n = 0; load_start = 0; rd_start = 0; ref_len = '0;
        s_data = '0; s_valid = 0; m_ready = 0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1;

        // Rejected starts.
        bad_start("rd_unloaded", 0, 1, 4);
        bad_start("len_zero",    1, 0, 0);
        bad_start("len_over",    1, 0, MAXL + 1);
        bad_start("len_max7",    1, 1, (1 << (PTR_WID + 1)) - 1);
        check("rej_loaded", ref_loaded, 0);

        // Directed load 0x0011..0x0014, then reads.
        q = {};
        for (int i = 0; i < 4; i++) q.push_back(WIDTH'(16'h0011 + i));
        load_ref(q, 0, 100);
        read_ref(0);
        read_ref(1);

        // load_start and rd_start together: load wins.
        q = {};
        for (int i = 0; i < 5; i++) q.push_back(WIDTH'($urandom));
        load_ref(q, 1, 100);
        read_ref(2);

        // Boundary lengths then random ones.
        for (int it = 0; it < 8; it++) begin
            if (it == 0)      len = 1;
            else if (it == 1) len = MAXL;
            else              len = $urandom_range(MAXL, 1);
            q = {};
            for (int i = 0; i < len; i++) q.push_back(WIDTH'($urandom));
            load_ref(q, 0, $urandom_range(100, 30));
            read_ref($urandom_range(2));
        end

        // Reset after two load beats.
        @(negedge clk);
        load_start = 1; ref_len = 8;
        @(negedge clk);
        load_start = 0; s_valid = 1; s_data = 16'hA001;
        @(negedge clk);
        s_data = 16'hA002;
        @(negedge clk);
        s_data = 16'hA003;
        #1;
        check("mid_busy", busy, 1);
        check("mid_addr", mem_addr_a, 2);
        #2;
        rst_n = 0;
        #1;
        check_all_zero("mid_rst");
        repeat (3) begin
            @(negedge clk); #1;
            check("mid_rst_done", done, 0);
        end
        s_valid = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk); #1;
        check("post_rst_done",   done, 0);
        check("post_rst_loaded", ref_loaded, 0);
        bad_start("post_rst_rd", 0, 1, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
